divide: RTL and testbench

// - Sign-magnitude 16-bit integer divider; inverse operation of the calculator's multiply unit.
// - Computes quotient and remainder by repeated subtraction.
// - Uses the same start/finish level handshake as multiply, so calculator_top sequences both identically.
// - One operation in flight; results held until the next operation.

---
 rtl/calc_pkg.sv | 6 +
 rtl/adder15.sv | 15 +
 rtl/divide.sv | 89 ++++++++
 tb/tb_divide.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: widths and divider state encoding shared by multiply, divide and calculator_top
package calc_pkg;
  localparam int MAG_W  = 15;
  localparam int DATA_W = 16;
  typedef enum logic [2:0] {IDLE, SET, CHECKSUB, SUB, FIN} div_state_t;
endpackage

// File: rtl/adder15.sv
// adder15: 15-bit unsigned add/subtract; ports i_a, i_b, i_sub (1=subtract), o_sum, o_cout (carry on add, borrow on subtract)
module adder15
  import calc_pkg::*;
(
  input  logic [MAG_W-1:0] i_a,
  input  logic [MAG_W-1:0] i_b,
  input  logic             i_sub,
  output logic [MAG_W-1:0] o_sum,
  output logic             o_cout
);
  logic [MAG_W:0] w_res;
  // with zero-extended operands the top bit of a subtraction is set exactly when i_a < i_b
  assign w_res = i_sub ? {1'b0, i_a} - {1'b0, i_b} : {1'b0, i_a} + {1'b0, i_b};
  assign {o_cout, o_sum} = w_res;
endmodule

// File: rtl/divide.sv
// divide: sign-magnitude 16-bit divider by repeated subtraction; ports clk, nRST, INn1 (dividend), INn2 (divisor), start, out (quotient), remainder, divZero, finish
module divide
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              nRST,
  input  logic [DATA_W-1:0] INn1,
  input  logic [DATA_W-1:0] INn2,
  input  logic              start,
  output logic [DATA_W-1:0] out,
  output logic [DATA_W-1:0] remainder,
  output logic              divZero,
  output logic              finish
);
  div_state_t        r_state, w_next;
  logic [DATA_W-1:0] r_n1;
  logic [MAG_W-1:0]  r_n2, r_r, r_q, r_diff, r_qinc;
  logic              r_qsign, r_rsign, r_dz;
  logic [MAG_W-1:0]  w_diff, w_inc_sum, w_qinc;
  logic              w_borrow, w_inc_c;
  logic [DATA_W-1:0] w_out, w_rem;
  adder15 u_sub (.i_a(r_r), .i_b(r_n2), .i_sub(1'b1), .o_sum(w_diff), .o_cout(w_borrow));
  adder15 u_inc (.i_a(r_q), .i_b(15'd1), .i_sub(1'b0), .o_sum(w_inc_sum), .o_cout(w_inc_c));
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:     w_next = start ? SET : IDLE;
      SET:      w_next = (INn2[MAG_W-1:0] == '0) ? FIN : CHECKSUB;
      CHECKSUB: w_next = w_borrow ? FIN : SUB;
      SUB:      w_next = CHECKSUB;
      FIN:      w_next = start ? FIN : IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_comb begin
    // q is bounded by |n1| so the carry never fires; saturating keeps it from wrapping regardless
    w_qinc = w_inc_c ? '1 : w_inc_sum;
    w_out  = r_dz ? {r_qsign, {MAG_W{1'b1}}} : {r_qsign, r_q};
    w_rem  = r_dz ? r_n1 : {r_rsign, r_r};
  end
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_n1      <= '0;
      r_n2      <= '0;
      r_r       <= '0;
      r_q       <= '0;
      r_diff    <= '0;
      r_qinc    <= '0;
      r_qsign   <= 1'b0;
      r_rsign   <= 1'b0;
      r_dz      <= 1'b0;
      out       <= '0;
      remainder <= '0;
      divZero   <= 1'b0;
      finish    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: finish <= 1'b0;
        SET: begin
          r_n1    <= INn1;
          r_n2    <= INn2[MAG_W-1:0];
          r_r     <= INn1[MAG_W-1:0];
          r_q     <= '0;
          r_qsign <= INn1[DATA_W-1] ^ INn2[DATA_W-1];
          r_rsign <= INn1[DATA_W-1];
          r_dz    <= INn2[MAG_W-1:0] == '0;
          divZero <= 1'b0;
        end
        CHECKSUB: begin
          r_diff <= w_diff;
          r_qinc <= w_qinc;
        end
        SUB: begin
          r_r <= r_diff;
          r_q <= r_qinc;
        end
        FIN: begin
          out       <= w_out;
          remainder <= w_rem;
          divZero   <= r_dz;
          finish    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divide.sv
// tb_divide: scoreboard bench for divide; expected results and latencies come from a behavioural model
module tb_divide;
  logic        clk, nRST, start, divZero, finish;
  logic [15:0] INn1, INn2, out, remainder;
  typedef struct {
    logic [15:0] out;
    logic [15:0] rem;
    logic        dz;
    int          lat;
  } exp_t;
  exp_t sb[$];
  int pass_cnt = 0;
  int total = 0;
  int probe = -1;
  divide dut (
    .clk(clk), .nRST(nRST), .INn1(INn1), .INn2(INn2), .start(start),
    .out(out), .remainder(remainder), .divZero(divZero), .finish(finish)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [14:0] m1, m2;
    m1 = a[14:0];
    m2 = b[14:0];
    if (m2 == 15'd0) begin
      e.out = {a[15] ^ b[15], 15'h7FFF};
      e.rem = a;
      e.dz  = 1'b1;
      e.lat = 3;
    end else begin
      e.out = {a[15] ^ b[15], m1 / m2};
      e.rem = {a[15], m1 % m2};
      e.dz  = 1'b0;
      e.lat = 2 * int'(m1 / m2) + 4;
    end
    sb.push_back(e);
    INn1  = a;
    INn2  = b;
    start = 1'b1;
  endtask
  task automatic wait_done(input string name, input int pre, input bit pulse);
    exp_t e;
    int cnt;
    cnt = pre;
    while (!finish && cnt < 70000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == probe) begin
        total++;
        if (divZero !== 1'b0) $display("FAIL %s divZero_after_SET: got %b expected 0", name, divZero);
        else pass_cnt++;
      end
    end
    e = sb.pop_front();
    total++;
    if (cnt !== e.lat) $display("FAIL %s latency: got %0d expected %0d", name, cnt, e.lat);
    else pass_cnt++;
    total++;
    if (out !== e.out) $display("FAIL %s out: got %h expected %h", name, out, e.out);
    else pass_cnt++;
    total++;
    if (remainder !== e.rem) $display("FAIL %s remainder: got %h expected %h", name, remainder, e.rem);
    else pass_cnt++;
    total++;
    if (divZero !== e.dz) $display("FAIL %s divZero: got %b expected %b", name, divZero, e.dz);
    else pass_cnt++;
    if (!pulse) begin
      start = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    total++;
    if (finish !== 1'b0) $display("FAIL %s finish_drop: got %b expected 0", name, finish);
    else pass_cnt++;
  endtask
  task automatic test_reset();
    nRST = 1'b0;
    start = 1'b0;
    INn1 = '0;
    INn2 = '0;
    #1;
    total++;
    if ({out, remainder, divZero, finish} !== 34'd0)
      $display("FAIL reset outputs: got %h/%h/%b/%b expected all 0", out, remainder, divZero, finish);
    else pass_cnt++;
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_basic();
    issue(16'd100, 16'd7);   wait_done("100/7", 0, 0);
    issue(16'd1000, 16'd10); wait_done("1000/10", 0, 0);
    issue(16'd77, 16'd9);    wait_done("77/9", 0, 0);
  endtask
  task automatic test_signs();
    issue(16'h8064, 16'h0007); wait_done("-100/7", 0, 0);
    issue(16'h8009, 16'h8003); wait_done("-9/-3", 0, 0);
    issue(16'h0003, 16'h8007); wait_done("3/-7", 0, 0);
  endtask
  task automatic test_div_zero();
    issue(16'h0005, 16'h0000); wait_done("5/0", 0, 0);
    issue(16'h8005, 16'h0000); wait_done("-5/0", 0, 0);
    issue(16'h0005, 16'h8000); wait_done("5/-0", 0, 0);
  endtask
  task automatic test_small();
    issue(16'd3, 16'd7); wait_done("3/7", 0, 0);
    issue(16'd0, 16'd5); wait_done("0/5", 0, 0);
    issue(16'd7, 16'd7); wait_done("7/7", 0, 0);
  endtask
  task automatic test_drop_start();
    issue(16'd25, 16'd5);
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("drop 25/5", 3, 1);
  endtask
  task automatic test_back_to_back();
    issue(16'd5, 16'd0);
    wait_done("b2b 5/0", 0, 0);
    total++;
    if (divZero !== 1'b1) $display("FAIL b2b divZero_hold: got %b expected 1", divZero);
    else pass_cnt++;
    probe = 2;
    issue(16'd10, 16'd3);
    wait_done("b2b 10/3", 0, 0);
    probe = -1;
  endtask
  task automatic test_reset_mid();
    exp_t d;
    issue(16'h7FFF, 16'h0001);
    repeat (50) @(negedge clk);
    total++;
    if (finish !== 1'b0) $display("FAIL midrst early_finish: got %b expected 0", finish);
    else pass_cnt++;
    nRST = 1'b0;
    #1;
    d = sb.pop_back();
    total++;
    if ({out, remainder, divZero, finish} !== 34'd0)
      $display("FAIL midrst outputs: got %h/%h/%b/%b expected all 0", out, remainder, divZero, finish);
    else pass_cnt++;
    start = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    issue(16'd100, 16'd7);
    wait_done("after reset 100/7", 0, 0);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_small();
    test_drop_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
